// File: rtl/if_fetch.sv
// if_fetch: RV32I fetch stage, one byte per memory request, little-endian assembly.
// Optional direct-mapped instruction cache enabled by defining IF_FETCH_ICACHE_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_flag_i,
    input  logic [31:0] br_target_i,
    input  logic        mem_busy_i,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] mem_a_o,
    output logic        mem_rd_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);
    // state   | meaning
    // S_FETCH | issuing byte reads and collecting bytes; cnt = bytes requested so far
    // S_HOLD  | assembled instruction presented to decode until it is taken

    localparam logic [31:0] NOP = 32'h0000_0013;

    if ((ICACHE_LINES < 1) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
        $error("ICACHE_LINES must be a power of two");
    end

    typedef enum logic {S_FETCH, S_HOLD} state_t;

    state_t          state, state_nxt;
    logic [2:0]      cnt;
    logic            pending;
    logic [31:0]     pc;
    logic [3:0][7:0] bytes;
    logic [31:0]     tgt_aligned;
    logic            req, done, hit;
    logic [31:0]     hit_word;

    logic            rd_nxt, valid_nxt;
    logic [31:0]     a_nxt, inst_nxt, pc_out_nxt;

    assign tgt_aligned = br_target_i & 32'hFFFF_FFFC;
    assign done = (state == S_FETCH) && (cnt == 3'd4) && !pending;
    assign req  = (state == S_FETCH) && (cnt < 3'd4) && !mem_busy_i && !hit;

`ifdef IF_FETCH_ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
    logic [31:0]             line_word [ICACHE_LINES];
    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;

    assign idx      = pc[IDX_W+1:2];
    assign tag      = pc[31:IDX_W+2];
    assign hit      = (state == S_FETCH) && (cnt == 3'd0) && line_valid[idx] && (line_tag[idx] == tag);
    assign hit_word = line_word[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            line_valid <= '0;
        else if (done && !br_flag_i)
            line_valid[idx] <= 1'b1;
    end

    // Tag/data need no reset: they are only read behind a set valid bit.
    always_ff @(posedge clk) begin
        if (done && !br_flag_i) begin
            line_tag[idx]  <= tag;
            line_word[idx] <= bytes;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = NOP;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (br_flag_i)
            state_nxt = S_FETCH;
        else begin
            case (state)
                S_FETCH: if (hit || done) state_nxt = S_HOLD;
                S_HOLD:  if (!stall_i)    state_nxt = S_FETCH;
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_comb begin
        rd_nxt     = 1'b0;
        a_nxt      = mem_a_o;
        valid_nxt  = inst_valid_o;
        inst_nxt   = inst_o;
        pc_out_nxt = pc_o;
        if (br_flag_i) begin
            valid_nxt = 1'b0;
            inst_nxt  = NOP;
        end else begin
            case (state)
                S_FETCH: begin
                    if (hit) begin
                        valid_nxt  = 1'b1;
                        inst_nxt   = hit_word;
                        pc_out_nxt = pc;
                    end else if (done) begin
                        valid_nxt  = 1'b1;
                        inst_nxt   = bytes;
                        pc_out_nxt = pc;
                    end else if (req) begin
                        rd_nxt = 1'b1;
                        a_nxt  = pc + {29'd0, cnt};
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        valid_nxt = 1'b0;
                        inst_nxt  = NOP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            cnt          <= 3'd0;
            pending      <= 1'b0;
            bytes        <= '0;
            mem_rd_o     <= 1'b0;
            mem_a_o      <= 32'd0;
            inst_valid_o <= 1'b0;
            inst_o       <= NOP;
            pc_o         <= RESET_PC;
        end else begin
            mem_rd_o     <= rd_nxt;
            mem_a_o      <= a_nxt;
            inst_valid_o <= valid_nxt;
            inst_o       <= inst_nxt;
            pc_o         <= pc_out_nxt;
            if (br_flag_i) begin
                pc      <= tgt_aligned;
                cnt     <= 3'd0;
                pending <= 1'b0;
                bytes   <= '0;
            end else if (state == S_FETCH) begin
                // cnt was already advanced past the byte now returning
                if (pending)
                    bytes[cnt[1:0] - 2'd1] <= mem_din_i;
                pending <= req;
                if (done || hit)
                    cnt <= 3'd0;
                else if (req)
                    cnt <= cnt + 3'd1;
            end else if (!stall_i) begin
                pc  <= pc + 32'd4;
                cnt <= 3'd0;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic
// against a queue-based behavioural model of the fetch stage.
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          NLINES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_flag_i = 1'b0;
    logic [31:0] br_target_i = 32'd0;
    logic        mem_busy_i = 1'b0;
    wire  [7:0]  mem_din_i;
    logic [31:0] mem_a_o;
    logic        mem_rd_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    int n_checks = 0;
    int n_err = 0;

    if_fetch #(.RESET_PC(32'h0000_0000), .ICACHE_LINES(NLINES)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .br_flag_i(br_flag_i),
        .br_target_i(br_target_i), .mem_busy_i(mem_busy_i), .mem_din_i(mem_din_i),
        .mem_a_o(mem_a_o), .mem_rd_o(mem_rd_o), .pc_o(pc_o), .inst_o(inst_o),
        .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h93;
            32'd1:   return 8'h00;
            32'd2:   return 8'h50;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    assign mem_din_i = mem_rd_o ? mem_byte(mem_a_o) : 8'hEE;

    // Behavioural model: bytes requested, bytes received, one read in flight.
    logic [31:0] m_pc, m_pc_o, m_inst, m_addr, m_fly_addr;
    logic        m_valid, m_rd, m_fly;
    int          n_req;
    logic [7:0]  q[$];
    logic        c_v [NLINES];
    logic [31:0] c_pc [NLINES];
    logic [31:0] c_word [NLINES];

    function automatic int cidx(input logic [31:0] p);
        return int'((p >> 2) % NLINES);
    endfunction

    function automatic logic cache_hit(input logic [31:0] p);
`ifdef IF_FETCH_ICACHE_EN
        return c_v[cidx(p)] && (c_pc[cidx(p)] == p);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_pc_o = 32'd0; m_inst = NOP; m_addr = 32'd0;
        m_valid = 1'b0; m_rd = 1'b0; m_fly = 1'b0; m_fly_addr = 32'd0;
        n_req = 0; q.delete();
        for (int i = 0; i < NLINES; i++) c_v[i] = 1'b0;
    endtask

    task automatic present(input logic [31:0] w);
        m_valid = 1'b1; m_inst = w; m_pc_o = m_pc; m_rd = 1'b0;
    endtask

    task automatic model_step();
        logic was_fly;
        logic [31:0] w;
        was_fly = m_fly;
        if (!rst) begin
            model_reset();
        end else if (br_flag_i) begin
            m_pc = br_target_i & 32'hFFFF_FFFC;
            q.delete(); n_req = 0; m_fly = 1'b0;
            m_valid = 1'b0; m_inst = NOP; m_rd = 1'b0;
        end else if (m_valid) begin
            m_rd = 1'b0;
            if (!stall_i) begin
                m_valid = 1'b0; m_inst = NOP; m_pc = m_pc + 32'd4;
            end
        end else begin
            if (m_fly) q.push_back(mem_byte(m_fly_addr));
            m_fly = 1'b0; m_rd = 1'b0;
            if (n_req == 0 && cache_hit(m_pc)) begin
                present(c_word[cidx(m_pc)]);
            end else if (n_req < 4) begin
                if (!mem_busy_i) begin
                    m_rd = 1'b1; m_addr = m_pc + n_req; m_fly_addr = m_addr;
                    m_fly = 1'b1; n_req++;
                end
            end else if (!was_fly) begin
                w = {q[3], q[2], q[1], q[0]};
                present(w);
                c_v[cidx(m_pc)] = 1'b1; c_pc[cidx(m_pc)] = m_pc; c_word[cidx(m_pc)] = w;
                q.delete(); n_req = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
        chk("inst", inst_o, m_inst);
        if (m_valid) chk("pc_o", pc_o, m_pc_o);
        chk("rd", {31'd0, mem_rd_o}, {31'd0, m_rd});
        if (m_rd) chk("addr", mem_a_o, m_addr);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (inst_valid_o) break;
        end
        chk("wait_valid", {31'd0, inst_valid_o}, 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_pc_o", pc_o, 32'd0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("rst_addr", mem_a_o, 32'd0);
    endtask

    initial begin
        logic br_prev;
        model_reset();
        repeat (2) cycle();
        chk_reset_vals();

        // basic fetch
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t1_rd", {31'd0, mem_rd_o}, 32'd1);
            chk("t1_addr", mem_a_o, i);
        end
        cycle();
        chk("t1_not_yet", {31'd0, inst_valid_o}, 32'd0);
        cycle();
        chk("t1_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t1_inst", inst_o, 32'h0050_0093);
        chk("t1_pc", pc_o, 32'd0);

        // stall hold
        stall_i = 1'b1;
        repeat (3) begin
            cycle();
            chk("t2_inst", inst_o, 32'h0050_0093);
            chk("t2_pc", pc_o, 32'd0);
            chk("t2_rd", {31'd0, mem_rd_o}, 32'd0);
        end
        stall_i = 1'b0;
        cycle();
        chk("t2_xfer", {31'd0, inst_valid_o}, 32'd0);
        cycle();
        chk("t2_addr", mem_a_o, 32'd4);
        wait_valid();
        chk("t2_pc4", pc_o, 32'd4);

        // redirect back to 0 wins over stall
        stall_i = 1'b1; br_flag_i = 1'b1; br_target_i = 32'd0;
        cycle();
        br_flag_i = 1'b0; stall_i = 1'b0;
        chk("redir_valid", {31'd0, inst_valid_o}, 32'd0);
`ifdef IF_FETCH_ICACHE_EN
        // cache hit
        cycle();
        chk("t6_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t6_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("t6_inst", inst_o, 32'h0050_0093);
        chk("t6_pc", pc_o, 32'd0);
`else
        // memory busy at cnt 2
        cycle(); chk("t3_a0", mem_a_o, 32'd0);
        cycle(); chk("t3_a1", mem_a_o, 32'd1);
        mem_busy_i = 1'b1;
        cycle(); chk("t3_busy1", {31'd0, mem_rd_o}, 32'd0);
        cycle(); chk("t3_busy2", {31'd0, mem_rd_o}, 32'd0);
        mem_busy_i = 1'b0;
        cycle(); chk("t3_a2", mem_a_o, 32'd2);
        cycle(); chk("t3_a3", mem_a_o, 32'd3);
        cycle(); chk("t3_not_yet", {31'd0, inst_valid_o}, 32'd0);
        cycle();
        chk("t3_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t3_inst", inst_o, 32'h0050_0093);
        chk("t3_pc", pc_o, 32'd0);
`endif

        // redirect coincident with transfer
        br_flag_i = 1'b1; br_target_i = 32'h200;
        cycle();
        br_flag_i = 1'b0;
        chk("t5_valid", {31'd0, inst_valid_o}, 32'd0);
        cycle(); chk("t5_addr", mem_a_o, 32'h200);
        wait_valid();
        chk("t5_pc", pc_o, 32'h200);

        // mid-fetch redirect
        cycle();
        cycle(); chk("t4_a0", mem_a_o, 32'h204);
        cycle(); chk("t4_a1", mem_a_o, 32'h205);
        br_flag_i = 1'b1; br_target_i = 32'h102;
        cycle();
        br_flag_i = 1'b0;
        chk("t4_rd", {31'd0, mem_rd_o}, 32'd0);
        cycle();
        chk("t4_addr", mem_a_o, 32'h100);
        wait_valid();
        chk("t4_pc", pc_o, 32'h100);

        // reset mid-fetch
        cycle(); cycle(); cycle();
        rst = 1'b0;
        #1;
        model_reset();
        chk_reset_vals();
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_refetch", mem_a_o, 32'd0);
        wait_valid();
        chk("rst_inst_again", inst_o, 32'h0050_0093);

        // pc wrap
        br_flag_i = 1'b1; br_target_i = 32'hFFFF_FFFE;
        cycle();
        br_flag_i = 1'b0;
        cycle(); chk("wrap_addr", mem_a_o, 32'hFFFF_FFFC);
        wait_valid();
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        wait_valid();
        chk("wrap_pc0", pc_o, 32'd0);

        // randomized traffic
        br_prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            stall_i    = ($urandom % 2) == 0;
            mem_busy_i = ($urandom % 4) == 0;
            br_flag_i  = !br_prev && (($urandom % 25) == 0);
            if (($urandom % 3) == 0)
                br_target_i = $urandom;
            else
                br_target_i = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2) | ($urandom % 4);
            br_prev = br_flag_i;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage. Produces pc/instruction pairs for the decode stage and owns the PC register.
- Fetches each 32-bit RV32I instruction from the shared byte-wide memory port, one byte per request, and assembles it little-endian.
- Holds the assembled instruction under downstream stall.
- Redirects on branch/jump from EX, discarding any partially fetched instruction.

Parameters:
- RESET_PC, 32'h00000000, PC loaded at reset.
- ICACHE_LINES, 16, number of direct-mapped cache lines (power of two). Used only with ICACHE_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- stall_i  in  1  decode cannot accept; hold current output.
- br_flag_i  in  1  redirect request from EX.
- br_target_i  in  32  redirect PC; bits [1:0] are forced to 0.
- mem_busy_i  in  1  memory port granted to the MEM stage this cycle; fetch must not request.
- mem_din_i  in  8  read data; valid the cycle after a request.
- mem_a_o  out  32  byte address.
- mem_rd_o  out  1  read request.
- pc_o  out  32  PC of inst_o.
- inst_o  out  32  assembled instruction.
- inst_valid_o  out  1  pc_o/inst_o valid for decode.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc register = RESET_PC; pc_o = RESET_PC.
  - inst_o = 32'h00000013; inst_valid_o = 0.
  - mem_rd_o = 0; mem_a_o = 0.
  - State FETCH, cnt = 0, pending = 0, byte buffer cleared.
  - Cache valid bits cleared.
  - Reset mid-fetch aborts the fetch.
- All outputs are registered. inst_o = 32'h00000013 whenever inst_valid_o = 0.
- State FETCH, byte counter cnt 0..4:
  - cnt 0-3, mem_busy_i = 0: mem_rd_o = 1, mem_a_o = pc+cnt, pending <= 1, cnt++.
  - If pending = 1, latch mem_din_i into byte[cnt-1].
  - cnt 4: no request; latch byte3. Next edge: inst_o = {b3,b2,b1,b0}, pc_o = pc, inst_valid_o = 1, go to HOLD.
  - Unstalled latency: first request at cycle T, inst_valid_o = 1 from T+5.
- mem_busy_i = 1 in FETCH:
  - mem_rd_o = 0; cnt holds; pending <= 0.
  - A byte returning from the previous cycle's request is still latched.
  - Each busy cycle adds exactly one cycle of latency.
- State HOLD:
  - Outputs are stable while stall_i = 1. No memory requests.
  - stall_i = 0: transfer occurs at that edge. pc <= pc+4, inst_valid_o <= 0, go to FETCH with cnt = 0.
  - FETCH then starts requesting at pc+4 in the cycle after the transfer.
- Redirect (br_flag_i = 1, single-cycle pulse, sampled at edge):
  - pc <= {br_target_i[31:2], 2'b00}; state FETCH, cnt 0, pending 0, inst_valid_o <= 0.
  - Byte buffer contents are discarded.
  - A byte returning in the next cycle is ignored.
  - Redirect has priority over stall, transfer and mem_busy_i.
  - Redirect coincident with a transfer yields target, not pc+4.
- PC arithmetic is modulo 2^32; pc+4 wraps from 32'hFFFFFFFC to 0.
- pc+cnt carries into upper bits; no alignment fault.

Optional Feature:
- Macro: IF_FETCH_ICACHE_EN.
- Defined:
  - Direct-mapped cache, ICACHE_LINES entries of {valid, tag, 32-bit word}.
  - Index = pc[log2(ICACHE_LINES)+1:2]; tag = pc[31:log2(ICACHE_LINES)+2].
  - Lookup in FETCH at cnt 0.
  - Hit: no mem_rd_o; inst_valid_o = 1 the next cycle (latency 1), inst_o = cached word.
  - Miss: byte fetch as above; line written when entering HOLD.
  - A redirect mid-miss writes nothing.
  - Valid bits are cleared only by reset (no self-modifying-code support).
- Undefined: no storage; every fetch takes the 5-cycle byte path.

Test Plan:
1. Basic fetch:
   - Stimulus: release reset; memory bytes 0..3 = 93,00,50,00.
   - Response: mem_rd_o with mem_a_o = 0,1,2,3 on consecutive cycles; inst_valid_o = 1 five cycles after the first request; inst_o = 32'h00500093, pc_o = 0.
2. Stall hold:
   - Stimulus: stall_i = 1 for 3 cycles while valid.
   - Response: pc_o/inst_o unchanged, mem_rd_o = 0. On release, next mem_a_o = 4 and pc_o = 4 on the next valid.
3. Memory busy:
   - Stimulus: mem_busy_i = 1 for 2 cycles when cnt = 2.
   - Response: mem_rd_o = 0 for those cycles, then mem_a_o = 2,3; inst_o still 32'h00500093; valid at T+7.
4. Mid-fetch redirect:
   - Stimulus: br_flag_i = 1, br_target_i = 32'h00000102 after byte 1 requested.
   - Response: next mem_a_o = 32'h100; old bytes discarded; pc_o = 32'h100 on next valid.
5. Redirect vs transfer:
   - Stimulus: br_flag_i = 1 and stall_i = 0 in HOLD at pc 0, target 32'h200.
   - Response: next pc_o = 32'h200 (not 4).
6. Cache hit (IF_FETCH_ICACHE_EN):
   - Stimulus: redirect back to 0 after first fetch.
   - Response: no mem_rd_o; inst_valid_o the cycle after redirect; inst_o = 32'h00500093.
